// File: rtl/uart_receiver_if.sv
// UART receive-side bus: serial line in, byte holding register out.
// The receiver drives the holding register and status flags (master);
// the consumer/line driver drives rx_in and rx_ack (slave).
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_in;
    logic                 rx_ack;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_busy;
    logic                 rx_frame_err;
    logic                 rx_overrun;

    modport master (
        input  rx_in,
        input  rx_ack,
        output rx_data,
        output rx_valid,
        output rx_busy,
        output rx_frame_err,
        output rx_overrun
    );

    modport slave (
        output rx_in,
        output rx_ack,
        input  rx_data,
        input  rx_valid,
        input  rx_busy,
        input  rx_frame_err,
        input  rx_overrun
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: synchronises the asynchronous serial line, locks onto the
// start bit, samples every bit at its mid-period and delivers complete bytes
// through a valid/ack holding register. Frame is idle-high, one start bit,
// DATA_BITS data bits LSB first, one stop bit, no parity.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic               clk,
    input  logic               rst,
    uart_receiver_if.master    rx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_q;
    logic                   syncMeta_q;
    logic                   rxSync_q;
    logic [CW-1:0]          clkCnt_q;
    logic [BW-1:0]          bitCnt_q;
    logic [DATA_BITS-1:0]   shiftReg_q;
    logic [DATA_BITS-1:0]   rxData_q;
    logic                   rxValid_q;
    logic                   rxBusy_q;
    logic                   frameErr_q;
    logic                   overrun_q;

    // Two-flop synchroniser; everything downstream looks only at rxSync_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncMeta_q <= 1'b1;
            rxSync_q   <= 1'b1;
        end else begin
            syncMeta_q <= rx.rx_in;
            rxSync_q   <= syncMeta_q;
        end
    end

    // Frame FSM with bit timing, shift register, holding register and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            clkCnt_q   <= '0;
            bitCnt_q   <= '0;
            shiftReg_q <= '0;
            rxData_q   <= '0;
            rxValid_q  <= 1'b0;
            rxBusy_q   <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;

            if (rx.rx_ack && rxValid_q) begin
                rxValid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    clkCnt_q <= '0;
                    bitCnt_q <= '0;
                    if (!rxSync_q) begin
                        state_q  <= START;
                        rxBusy_q <= 1'b1;
                    end
                end

                START: begin
                    if (clkCnt_q == HALF_LAST) begin
                        clkCnt_q <= '0;
                        if (!rxSync_q) begin
                            state_q <= DATA;
                        end else begin
                            state_q  <= IDLE;
                            rxBusy_q <= 1'b0;
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end

                DATA: begin
                    if (clkCnt_q == BIT_LAST) begin
                        clkCnt_q   <= '0;
                        shiftReg_q <= {rxSync_q, shiftReg_q[DATA_BITS-1:1]};
                        if (bitCnt_q == DATA_LAST) begin
                            bitCnt_q <= '0;
                            state_q  <= STOP;
                        end else begin
                            bitCnt_q <= bitCnt_q + 1'b1;
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end

                STOP: begin
                    if (clkCnt_q == BIT_LAST) begin
                        clkCnt_q <= '0;
                        state_q  <= IDLE;
                        rxBusy_q <= 1'b0;
                        if (rxSync_q) begin
                            if (!rxValid_q || rx.rx_ack) begin
                                rxData_q  <= shiftReg_q;
                                rxValid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                    end else begin
                        clkCnt_q <= clkCnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    rxBusy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx.rx_data      = rxData_q;
    assign rx.rx_valid     = rxValid_q;
    assign rx.rx_busy      = rxBusy_q;
    assign rx.rx_frame_err = frameErr_q;
    assign rx.rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver. A per-cycle line queue drives the
// serial input; a frame-level model predicts, from each queued frame's
// start time, when its stop bit is sampled and what the holding register,
// flags and busy indicator must show every cycle.
module tb_uart_receiver;

    localparam int CPB = 16;
    localparam int DB  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_receiver_if #(.DATA_BITS(DB)) bus ();

    uart_receiver #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus)
    );

    // Free-running 100 MHz-style clock.
    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [DB-1:0] data;
        bit            ok;
    } stopEvent_t;

    typedef struct {
        int lo;
        int hi;
    } span_t;

    bit          lineQ[$];
    stopEvent_t  evQ[$];
    span_t       busyQ[$];

    int            cyc          = 0;
    int            checks       = 0;
    int            errors       = 0;
    int            ackMode      = 0;
    int            ackAt        = -1;
    int            validRise    = -1;
    logic          prevDutValid = 1'b0;
    logic          expValid     = 1'b0;
    logic          prevExpValid = 1'b0;
    logic          expErr       = 1'b0;
    logic          expOvr       = 1'b0;
    logic          expBusy      = 1'b0;
    logic [DB-1:0] expData      = '0;

    function automatic bit busyAt(input int c);
        foreach (busyQ[i]) begin
            if (c >= busyQ[i].lo && c <= busyQ[i].hi) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs, drive this cycle's inputs, advance the model.
    task automatic applyStimulus(input bit rstNow);
        bit         ackNow;
        logic       nv;
        stopEvent_t ev;

        @(negedge clk);
        cyc++;

        checkOutput("rx_valid", 32'(bus.rx_valid), 32'(expValid));
        checkOutput("rx_data", 32'(bus.rx_data), 32'(expData));
        checkOutput("rx_frame_err", 32'(bus.rx_frame_err), 32'(expErr));
        checkOutput("rx_overrun", 32'(bus.rx_overrun), 32'(expOvr));
        checkOutput("rx_busy", 32'(bus.rx_busy), 32'(expBusy));

        if (bus.rx_valid === 1'b1 && prevDutValid !== 1'b1 && validRise < 0) validRise = cyc;
        prevDutValid = bus.rx_valid;

        rst = rstNow;
        if (rstNow) begin
            lineQ.delete();
            bus.rx_in = 1'b1;
        end else begin
            bus.rx_in = (lineQ.size() > 0) ? lineQ.pop_front() : 1'b1;
        end

        ackNow = ((ackMode == 1) && expValid && prevExpValid)
              || ((ackMode == 2) && ($urandom_range(0, 3) == 0))
              || (cyc == ackAt);
        bus.rx_ack = ackNow;

        prevExpValid = expValid;
        if (rstNow) begin
            expValid = 1'b0;
            expData  = '0;
            expErr   = 1'b0;
            expOvr   = 1'b0;
            evQ.delete();
            busyQ.delete();
        end else begin
            nv     = expValid;
            expErr = 1'b0;
            expOvr = 1'b0;
            if (ackNow && expValid) nv = 1'b0;
            if (evQ.size() > 0 && evQ[0].cyc == cyc) begin
                ev = evQ.pop_front();
                if (ev.ok) begin
                    if (!expValid || ackNow) begin
                        expData = ev.data;
                        nv      = 1'b1;
                    end else begin
                        expOvr = 1'b1;
                    end
                end else begin
                    expErr = 1'b1;
                end
            end
            expValid = nv;
        end
        expBusy = busyAt(cyc + 1);
    endtask

    // Queue a frame; returns the first cycle the synchronised line is low
    // and the cycle in which the stop bit is sampled.
    task automatic sendFrame(input logic [DB-1:0] d, input bit stopOk, input int gap,
                             output int s, output int stopCyc);
        int startPop;
        startPop = cyc + 1 + lineQ.size();
        s        = startPop + 2;
        stopCyc  = s + CPB / 2 + (DB + 1) * CPB;
        repeat (CPB) lineQ.push_back(1'b0);
        for (int i = 0; i < DB; i++) begin
            repeat (CPB) lineQ.push_back(d[i]);
        end
        repeat (CPB) lineQ.push_back(stopOk);
        repeat (gap) lineQ.push_back(1'b1);
        evQ.push_back('{stopCyc, d, stopOk});
        busyQ.push_back('{s + 1, stopCyc});
        if (!stopOk) busyQ.push_back('{stopCyc + 2, stopCyc + 1 + CPB / 2});
    endtask

    task automatic sendGlitch(input int lowCycles, input int gap);
        int s;
        s = cyc + 1 + lineQ.size() + 2;
        repeat (lowCycles) lineQ.push_back(1'b0);
        repeat (gap) lineQ.push_back(1'b1);
        busyQ.push_back('{s + 1, s + CPB / 2});
    endtask

    task automatic drain(input int extra);
        int n;
        n = lineQ.size() + extra;
        repeat (n) applyStimulus(1'b0);
    endtask

    // Directed scenarios followed by a randomised frame stream.
    initial begin
        int s1, st, stop3;
        logic [DB-1:0] d;
        bit ok;

        bus.rx_in  = 1'b1;
        bus.rx_ack = 1'b0;
        rst        = 1'b1;
        repeat (3) applyStimulus(1'b1);
        applyStimulus(1'b0);

        $display("[TB] single frame 0x55 and latency");
        ackMode   = 0;
        validRise = -1;
        sendFrame(8'h55, 1'b1, CPB, s1, st);
        drain(4);
        checkOutput("latency", 32'(validRise - s1), 32'd153);
        ackAt = cyc + 1;
        repeat (3) applyStimulus(1'b0);
        ackAt = -1;

        $display("[TB] back-to-back 0xA3, 0x0F with ack");
        ackMode = 1;
        sendFrame(8'hA3, 1'b1, 0, s1, st);
        sendFrame(8'h0F, 1'b1, CPB, s1, st);
        drain(4);

        $display("[TB] overrun then ack coincident with stop sample");
        ackMode = 0;
        sendFrame(8'h12, 1'b1, 0, s1, st);
        sendFrame(8'h34, 1'b1, 0, s1, st);
        sendFrame(8'h56, 1'b1, CPB, s1, stop3);
        ackAt = stop3;
        drain(4);
        ackAt   = -1;
        ackMode = 1;
        repeat (4) applyStimulus(1'b0);

        $display("[TB] frame error keeps held byte");
        ackMode = 0;
        sendFrame(8'h99, 1'b1, CPB, s1, st);
        sendFrame(8'hFF, 1'b0, 2 * CPB, s1, st);
        drain(4);
        ackMode = 1;
        sendFrame(8'h81, 1'b1, CPB, s1, st);
        drain(4);

        $display("[TB] idle glitch and mid-frame reset");
        sendGlitch(4, 2 * CPB);
        drain(4);
        sendFrame(8'hC3, 1'b1, CPB, s1, st);
        repeat (60) applyStimulus(1'b0);
        applyStimulus(1'b1);
        repeat (4) applyStimulus(1'b0);
        sendFrame(8'h3C, 1'b1, CPB, s1, st);
        drain(4);

        $display("[TB] randomised frames");
        ackMode = 2;
        for (int k = 0; k < 12; k++) begin
            d  = DB'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            sendFrame(d, ok, ok ? int'($urandom_range(0, CPB)) : 2 * CPB, s1, st);
        end
        drain(8);
        ackMode = 1;
        repeat (10) applyStimulus(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
